// File: rtl/io_core_pkg.sv
// Shared constants, region type and word-count helper for the io_core slice.
// Change flags are built only when IO_CORE_CHANGE_FLAGS_EN is defined.
package io_core_pkg;

   localparam int BUS_W           = 16;
   localparam int CTRL_OFS        = 0;
   localparam int STATUS_OFS      = 1;
   localparam int IN_OFS          = 2;
   localparam int CTRL_STROBE_BIT = 0;
   localparam int CTRL_CONT_BIT   = 1;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_CTRL,
      REG_STATUS,
      REG_IN,
      REG_OUT
   } region_e;

   function automatic int words(input int w);
      return (w + 15) / 16;
   endfunction

endpackage

// File: rtl/io_core_word_decode.sv
// Maps a bus address to a register region, probe index and word index.
// Purely combinational; the address map is fixed by the parameters.
module io_core_word_decode
   import io_core_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          N_IN      = 4,
   parameter int          WI        = 2,
   parameter int          N_OUT     = 4,
   parameter int          WO        = 2
) (
   input  logic [15:0] addr_i,
   output region_e     region_o,
   output logic [3:0]  probe_o,
   output logic [1:0]  word_o
);

   localparam logic [31:0] IN_END  = 32'(IN_OFS + N_IN * WI);
   localparam logic [31:0] OUT_END = 32'(IN_OFS + N_IN * WI + N_OUT * WO);

   logic [31:0] ofs;
   logic [31:0] rel;

   // Addresses below BASE_ADDR wrap to huge offsets and fall out of window.
   assign ofs = {16'h0, addr_i} - {16'h0, BASE_ADDR};

   always_comb begin
      region_o = REG_NONE;
      probe_o  = '0;
      word_o   = '0;
      rel      = '0;
      if (ofs == 32'(CTRL_OFS)) begin
         region_o = REG_CTRL;
      end else if (ofs == 32'(STATUS_OFS)) begin
         region_o = REG_STATUS;
      end else if (ofs < IN_END) begin
         region_o = REG_IN;
         rel      = ofs - 32'(IN_OFS);
         probe_o  = 4'(rel / 32'(WI));
         word_o   = 2'(rel % 32'(WI));
      end else if (ofs < OUT_END) begin
         region_o = REG_OUT;
         rel      = ofs - IN_END;
         probe_o  = 4'(rel / 32'(WO));
         word_o   = 2'(rel % 32'(WO));
      end
   end

endmodule

// File: rtl/io_core_multi.sv
// Memory-mapped I/O probe core on the daisy-chained 16-bit register bus.
// Define IO_CORE_CHANGE_FLAGS_EN to build the sticky input-change flags.
module io_core_multi
   import io_core_pkg::*;
#(
   parameter logic [15:0]            BASE_ADDR = 16'h0000,
   parameter int                     N_IN      = 4,
   parameter int                     IN_W      = 20,
   parameter int                     N_OUT     = 4,
   parameter int                     OUT_W     = 20,
   parameter logic [N_OUT*OUT_W-1:0] OUT_INIT  = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_IN*IN_W-1:0]   in_probes,
   output logic [N_OUT*OUT_W-1:0] out_probes,
   input  logic [15:0]            addr_i,
   input  logic [15:0]            data_i,
   input  logic                   rw_i,
   input  logic                   valid_i,
   output logic [15:0]            addr_o,
   output logic [15:0]            data_o,
   output logic                   rw_o,
   output logic                   valid_o
);

   localparam int WI = words(IN_W);
   localparam int WO = words(OUT_W);

   region_e    region;
   logic [3:0] probe;
   logic [1:0] word;

   io_core_word_decode #(
      .BASE_ADDR (BASE_ADDR),
      .N_IN      (N_IN),
      .WI        (WI),
      .N_OUT     (N_OUT),
      .WO        (WO)
   ) u_dec (
      .addr_i   (addr_i),
      .region_o (region),
      .probe_o  (probe),
      .word_o   (word)
   );

   logic [1:0]             ctrl_q, ctrl_d;
   logic                   strobe_q;
   logic                   upd;
   logic [N_IN*IN_W-1:0]   in_buf_q;
   logic [N_OUT*OUT_W-1:0] out_buf_q, out_buf_d;
   logic [N_OUT*OUT_W-1:0] out_probes_q;
   logic [15:0]            addr_q, data_q, data_d;
   logic                   rw_q, valid_q;
   logic [15:0]            status_word, rd_word;
   logic                   rd_hit, wr_hit;
   logic [WI*BUS_W-1:0]    in_pad;
   logic [WO*BUS_W-1:0]    out_pad, wr_pad;

   assign rd_hit = valid_i & ~rw_i & (region != REG_NONE);
   assign wr_hit = valid_i & rw_i;
   assign upd    = (ctrl_q[CTRL_STROBE_BIT] & ~strobe_q)
                 | ctrl_q[CTRL_CONT_BIT];

   // Probes are zero-padded to whole bus words before word selection.
   always_comb begin
      rd_word = '0;
      in_pad  = '0;
      out_pad = '0;
      unique case (region)
         REG_CTRL:   rd_word = 16'(ctrl_q);
         REG_STATUS: rd_word = status_word;
         REG_IN: begin
            for (int i = 0; i < N_IN; i++) begin
               if (probe == 4'(i)) begin
                  in_pad = (WI*BUS_W)'(in_buf_q[i*IN_W +: IN_W]);
                  for (int k = 0; k < WI; k++)
                     if (word == 2'(k)) rd_word = in_pad[k*BUS_W +: BUS_W];
               end
            end
         end
         REG_OUT: begin
            for (int j = 0; j < N_OUT; j++) begin
               if (probe == 4'(j)) begin
                  out_pad = (WO*BUS_W)'(out_buf_q[j*OUT_W +: OUT_W]);
                  for (int k = 0; k < WO; k++)
                     if (word == 2'(k)) rd_word = out_pad[k*BUS_W +: BUS_W];
               end
            end
         end
         default: rd_word = '0;
      endcase
   end

   always_comb begin
      out_buf_d = out_buf_q;
      wr_pad    = '0;
      if (wr_hit && region == REG_OUT) begin
         for (int j = 0; j < N_OUT; j++) begin
            if (probe == 4'(j)) begin
               wr_pad = (WO*BUS_W)'(out_buf_q[j*OUT_W +: OUT_W]);
               for (int k = 0; k < WO; k++)
                  if (word == 2'(k)) wr_pad[k*BUS_W +: BUS_W] = data_i;
               out_buf_d[j*OUT_W +: OUT_W] = wr_pad[OUT_W-1:0];
            end
         end
      end
   end

   assign ctrl_d = (wr_hit && region == REG_CTRL) ? data_i[1:0] : ctrl_q;
   assign data_d = rd_hit ? rd_word : data_i;

`ifdef IO_CORE_CHANGE_FLAGS_EN
   logic [N_IN-1:0] status_q, status_set, status_clr;

   always_comb begin
      status_set = '0;
      for (int i = 0; i < N_IN; i++)
         status_set[i] = upd &&
            (in_probes[i*IN_W +: IN_W] != in_buf_q[i*IN_W +: IN_W]);
   end

   assign status_clr = (wr_hit && region == REG_STATUS)
                     ? data_i[N_IN-1:0] : '0;

   // A set and a clear on the same edge leave the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) status_q <= '0;
      else     status_q <= (status_q & ~status_clr) | status_set;
   end

   assign status_word = 16'(status_q);
`else
   assign status_word = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q       <= '0;
         data_q       <= '0;
         rw_q         <= 1'b0;
         valid_q      <= 1'b0;
         ctrl_q       <= '0;
         strobe_q     <= 1'b0;
         in_buf_q     <= '0;
         out_buf_q    <= OUT_INIT;
         out_probes_q <= OUT_INIT;
      end else begin
         addr_q    <= addr_i;
         data_q    <= data_d;
         rw_q      <= rw_i;
         valid_q   <= valid_i;
         ctrl_q    <= ctrl_d;
         strobe_q  <= ctrl_q[CTRL_STROBE_BIT];
         out_buf_q <= out_buf_d;
         if (upd) begin
            in_buf_q     <= in_probes;
            out_probes_q <= out_buf_q;
         end
      end
   end

   assign addr_o     = addr_q;
   assign data_o     = data_q;
   assign rw_o       = rw_q;
   assign valid_o    = valid_q;
   assign out_probes = out_probes_q;

endmodule

// File: tb/tb_io_core_multi.sv
// Directed bench for io_core_multi with default geometry.
// Flag expectations follow IO_CORE_CHANGE_FLAGS_EN.
module tb_io_core_multi;

   localparam logic [79:0] INIT = {20'd4, 20'd3, 20'd2, 20'd1};

   logic        clk = 1'b0;
   logic        rst;
   logic [79:0] in_probes;
   logic [79:0] out_probes;
   logic [15:0] addr_i, data_i, addr_o, data_o;
   logic        rw_i, valid_i, rw_o, valid_o;
   logic [15:0] q;
   logic [15:0] st_exp;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   io_core_multi #(
      .BASE_ADDR (16'h0000),
      .N_IN      (4),
      .IN_W      (20),
      .N_OUT     (4),
      .OUT_W     (20),
      .OUT_INIT  (INIT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_probes  (in_probes),
      .out_probes (out_probes),
      .addr_i     (addr_i),
      .data_i     (data_i),
      .rw_i       (rw_i),
      .valid_i    (valid_i),
      .addr_o     (addr_o),
      .data_o     (data_o),
      .rw_o       (rw_o),
      .valid_o    (valid_o)
   );

   task automatic check(input string tag, input logic [79:0] got,
                        input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic rw, input logic [15:0] a,
                       input logic [15:0] d, output logic [15:0] r);
      @(negedge clk);
      addr_i  = a;
      data_i  = d;
      rw_i    = rw;
      valid_i = 1'b1;
      check("valid_o idle", valid_o, 0);
      @(posedge clk);
      #1;
      check("valid_o", valid_o, 1);
      check("addr_o", addr_o, a);
      check("rw_o", rw_o, rw);
      r = data_o;
      @(negedge clk);
      valid_i = 1'b0;
      rw_i    = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      logic [15:0] r;
      xfer(1'b1, a, d, r);
   endtask

   task automatic rdchk(input string tag, input logic [15:0] a,
                        input logic [15:0] exp);
      logic [15:0] r;
      xfer(1'b0, a, 16'h0, r);
      check(tag, r, exp);
   endtask

   function automatic logic [15:0] rst_word(input int k);
      if (k >= 10 && k % 2 == 0) return 16'((k - 10) / 2 + 1);
      return 16'h0;
   endfunction

   task automatic read_all(input string tag);
      for (int k = 0; k < 18; k++)
         rdchk($sformatf("%s +%0d", tag, k), 16'(k), rst_word(k));
      check({tag, " out_probes"}, out_probes, INIT);
   endtask

   initial begin
      rst       = 1'b1;
      in_probes = '0;
      addr_i    = '0;
      data_i    = '0;
      rw_i      = 1'b0;
      valid_i   = 1'b0;
      #1;
      check("rst valid_o", valid_o, 0);
      check("rst out_probes", out_probes, INIT);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      read_all("por");

      wr(16'd10, 16'hBEEF);
      wr(16'd11, 16'h000F);
      wr(16'd13, 16'hFFFF);
      rdchk("out0 w0", 16'd10, 16'hBEEF);
      rdchk("out0 w1", 16'd11, 16'h000F);
      rdchk("out1 w1 trunc", 16'd13, 16'h000F);
      check("out held", out_probes[19:0], 20'h00001);
      wr(16'd0, 16'h0001);
      check("no upd yet", out_probes[19:0], 20'h00001);
      @(posedge clk);
      #1;
      check("strobe apply", out_probes[39:0], {20'hF0002, 20'hFBEEF});

      wr(16'd0, 16'h0000);
      in_probes[19:0] = 20'hABCDE;
      wr(16'd0, 16'h0001);
      rdchk("in0 w0", 16'd2, 16'hBCDE);
      rdchk("in0 w1", 16'd3, 16'h000A);
      in_probes[19:0] = 20'h12345;
      wr(16'd0, 16'h0001);
      repeat (3) @(negedge clk);
      rdchk("strobe held", 16'd2, 16'hBCDE);
      wr(16'd0, 16'h0000);

      xfer(1'b0, 16'h0100, 16'h1234, q);
      check("pass rd", q, 16'h1234);
      xfer(1'b1, 16'h0100, 16'h5678, q);
      check("pass wr", q, 16'h5678);
      wr(16'd2, 16'hFFFF);
      rdchk("in ro", 16'd2, 16'hBCDE);

      wr(16'd0, 16'h0002);
      repeat (2) @(negedge clk);
      rdchk("cont track", 16'd2, 16'h2345);
      wr(16'd1, 16'hFFFF);
      rdchk("status clr", 16'd1, 16'h0000);
      in_probes[19:0] = 20'h55555;
      repeat (2) @(negedge clk);
`ifdef IO_CORE_CHANGE_FLAGS_EN
      st_exp = 16'h0001;
`else
      st_exp = 16'h0000;
`endif
      rdchk("status set", 16'd1, st_exp);
      rdchk("cont w0", 16'd2, 16'h5555);
      rdchk("cont w1", 16'd3, 16'h0005);
      wr(16'd1, 16'h0001);
      rdchk("status w1c", 16'd1, 16'h0000);
      wr(16'd12, 16'h0077);
      repeat (2) @(negedge clk);
      check("cont out", out_probes[39:20], 20'hF0077);

      @(negedge clk);
      addr_i  = 16'd10;
      rw_i    = 1'b0;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      check("mid valid_o", valid_o, 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst valid_o now", valid_o, 0);
      check("rst data_o now", data_o, 0);
      check("rst out now", out_probes, INIT);
      @(negedge clk);
      valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      read_all("post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
